clk_div_ctrl: RTL and testbench
===============================

Name: clk_div_ctrl

Overview:
- Runtime-programmable integer clock divider controller.
- Owns the divide counter and the 50%-duty output stage for both odd and even ratios.
- Accepts ratio changes over a valid/ready handshake and applies them only at period boundaries, so the output never glitches.
- Sits between the config/register block and downstream clocked logic; replaces the fixed-ratio odd divider wherever the ratio must change in system.

Parameters:
- CNT_W, 4, width of ratio and counter; legal ratio range is 2..2^CNT_W-1.
- DEF_DIV, 5, ratio loaded at reset; must be within the legal range.

Ports:
- clk  in  1  source clock
- restn  in  1  asynchronous active-low reset
- en  in  1  level; high = run divider, low = stop at next period end
- cfg_valid  in  1  new-ratio request
- cfg_div  in  CNT_W  requested ratio N
- cfg_ready  out  1  request accepted when cfg_valid & cfg_ready
- cfg_err  out  1  one-cycle pulse: accepted ratio was illegal (<2), discarded
- clk_div  out  1  divided clock, 50% duty (odd N: high N/2 source cycles)
- period_tick  out  1  one-cycle pulse on the last count of each running period
- busy  out  1  state != IDLE
- cur_div  out  CNT_W  ratio currently in effect

Behaviour:
- Reset (async, restn low):
  - state=IDLE, cnt=0, div_q=DEF_DIV, no pending ratio.
  - clk_div=0, period_tick=0, cfg_err=0, busy=0, cfg_ready=1, cur_div=DEF_DIV.
  - Reset mid-period forces clk_div low immediately (both edge flops cleared).
- States:
  - IDLE: cnt held 0, clk_div low.
  - RUN: counting.
  - PEND: running, ratio change queued.
  - STOP: running, finishing last period.
- Counter: in RUN/PEND/STOP, cnt goes 0..div_q-1 and wraps to 0. At cnt==div_q-1, period_tick=1.
- Duty stage:
  - p (posedge flop) = 1 for cnt in [0, ceil(N/2)-1].
  - n = p re-registered on negedge clk.
  - Even N: clk_div=p. Odd N: clk_div=p&n.
  - Parity select uses div_q and changes only at a boundary.
- Start: en high in IDLE → RUN next posedge with cnt=0. clk_div rises on that same edge (odd N: half a cycle later).
- Stop: en low in RUN → STOP. At the boundary → IDLE; clk_div already low, no runt pulse. en high again during STOP → back to RUN, no gap.
- Config handshake:
  - cfg_ready = (state==IDLE) | (state==RUN).
  - Accepted N<2 → cfg_err pulse next cycle; div_q and state unchanged.
  - Legal N in IDLE → div_q=N next cycle.
  - Legal N in RUN → pending=N, state=PEND. At the next boundary (cnt==div_q-1): div_q=pending, cnt=0, state=RUN (or IDLE if en low).
  - Acceptance on the boundary cycle itself → the following period still runs at the old ratio; the new ratio applies at the next boundary.
- Simultaneous en low and pending change: apply the ratio at the boundary, then go IDLE.
- In PEND/STOP, cfg_ready=0; requests stall.
- cur_div = div_q.

Decomposition:
- Package clk_div_pkg: state enum (IDLE, RUN, PEND, STOP), MIN_DIV=2, helper for high-phase length ceil(N/2).
- Sub-module clk_div_duty: posedge p flop, negedge n flop, odd/even combine. Inputs: cnt, div_q, run. Keeps all negedge logic isolated for STA/CDC review.

Test Plan:
- Reset, en=1, DEF_DIV=5 → clk_div period 5 clk, high 2.5 clk; period_tick every 5 cycles; busy=1.
- In IDLE, cfg_div=4 accepted, then en=1 → period 4, high exactly 2 clk, cur_div=4.
- Running at N=5, request N=6 mid-period → current period completes at 5, next period is 6. No high pulse shorter than 2.5 clk; cfg_ready low until the switch.
- cfg_div=1 and cfg_div=0 accepted → cfg_err one-cycle pulse each; cur_div unchanged; output unaffected.
- en dropped at cnt=1 with N=7 → output completes its 3.5-clk high; state IDLE after cnt=6; busy falls; clk_div stays low.
- restn asserted while clk_div high → clk_div=0 immediately. After release, cur_div=DEF_DIV and cfg_ready=1.

Source files
------------

// File: rtl/clk_div_pkg.sv
// Shared types and helpers for the runtime-programmable integer clock divider.
package clk_div_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      PEND = 2'd2,
      STOP = 2'd3
   } state_t;

   localparam int unsigned MIN_DIV = 2;

   // Length of the high phase in source cycles: ceil(n/2).
   function automatic int unsigned high_len(input int unsigned n);
      return (n + 1) / 2;
   endfunction

endpackage

// File: rtl/clk_div_duty.sv
// 50%-duty output stage: posedge phase flop, negedge copy, odd/even combine.
// All negedge-clocked logic of the divider lives here.
module clk_div_duty
   import clk_div_pkg::*;
#(
   parameter int CNT_W = 4
) (
   input  logic             clk,
   input  logic             restn,
   input  logic [CNT_W-1:0] cnt_i,
   input  logic [CNT_W-1:0] div_i,
   input  logic             run_i,
   output logic             clk_div_o
);

   // cnt_i/div_i/run_i are next-cycle values, so p_q lines up with the counter register.
   logic [CNT_W-1:0] high_w;
   logic             p_d;
   logic             p_q;
   logic             n_q;
   logic             odd_q;

   assign high_w = CNT_W'(high_len(32'(div_i)));
   assign p_d    = run_i & (cnt_i < high_w);

   always_ff @(posedge clk or negedge restn) begin
      if (!restn) begin
         p_q   <= 1'b0;
         odd_q <= 1'b0;
      end else begin
         p_q   <= p_d;
         odd_q <= div_i[0];
      end
   end

   always_ff @(negedge clk or negedge restn) begin
      if (!restn) begin
         n_q <= 1'b0;
      end else begin
         n_q <= p_q;
      end
   end

   // Odd ratios trim the leading half cycle so the high time is N/2 source cycles.
   assign clk_div_o = odd_q ? (p_q & n_q) : p_q;

endmodule

// File: rtl/clk_div_ctrl.sv
// Runtime-programmable integer clock divider; ratio changes land only on period boundaries.
//   state | meaning
//   IDLE  | stopped, cnt held 0, clk_div low
//   RUN   | counting at div_q, accepts new ratios
//   PEND  | counting, new ratio waits for the period boundary
//   STOP  | counting, last period before IDLE
module clk_div_ctrl
   import clk_div_pkg::*;
#(
   parameter int CNT_W   = 4,
   parameter int DEF_DIV = 5
) (
   input  logic             clk,
   input  logic             restn,
   input  logic             en,
   input  logic             cfg_valid,
   input  logic [CNT_W-1:0] cfg_div,
   output logic             cfg_ready,
   output logic             cfg_err,
   output logic             clk_div,
   output logic             period_tick,
   output logic             busy,
   output logic [CNT_W-1:0] cur_div
);

   localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] DEF  = CNT_W'(DEF_DIV);
   localparam logic [CNT_W-1:0] MINV = CNT_W'(MIN_DIV);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] div_q, div_d;
   logic [CNT_W-1:0] pend_q, pend_d;
   logic             err_q, err_d;
   logic             running;
   logic             boundary;
   logic             accept;
   logic             legal;

   assign running   = (state_q != IDLE);
   assign boundary  = running && (cnt_q == div_q - ONE);
   assign cfg_ready = (state_q == IDLE) || (state_q == RUN);
   assign accept    = cfg_valid && cfg_ready;
   assign legal     = (cfg_div >= MINV);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      div_d   = div_q;
      pend_d  = pend_q;
      err_d   = accept && !legal;
      if (running) begin
         cnt_d = boundary ? '0 : cnt_q + ONE;
      end
      case (state_q)
         IDLE: begin
            cnt_d = '0;
            if (accept && legal) begin
               div_d = cfg_div;
            end
            if (en) begin
               state_d = RUN;
            end
         end
         RUN: begin
            // A queued ratio takes priority; en is re-examined at the boundary it lands on.
            if (accept && legal) begin
               pend_d  = cfg_div;
               state_d = PEND;
            end else if (!en) begin
               state_d = boundary ? IDLE : STOP;
            end
         end
         PEND: begin
            if (boundary) begin
               div_d   = pend_q;
               state_d = en ? RUN : IDLE;
            end
         end
         STOP: begin
            if (en) begin
               state_d = RUN;
            end else if (boundary) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge restn) begin
      if (!restn) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         div_q   <= DEF;
         pend_q  <= DEF;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         div_q   <= div_d;
         pend_q  <= pend_d;
         err_q   <= err_d;
      end
   end

   clk_div_duty #(
      .CNT_W (CNT_W)
   ) u_duty (
      .clk       (clk),
      .restn     (restn),
      .cnt_i     (cnt_d),
      .div_i     (div_d),
      .run_i     (state_d != IDLE),
      .clk_div_o (clk_div)
   );

   assign period_tick = boundary;
   assign busy        = running;
   assign cur_div     = div_q;
   assign cfg_err     = err_q;

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Scoreboard bench for clk_div_ctrl: expected periods and cfg_err pulses are queued by stimulus.
module tb_clk_div_ctrl;

   localparam int CNT_W   = 4;
   localparam int DEF_DIV = 5;

   logic             clk = 1'b0;
   logic             restn;
   logic             en;
   logic             cfg_valid;
   logic [CNT_W-1:0] cfg_div;
   logic             cfg_ready;
   logic             cfg_err;
   logic             clk_div;
   logic             period_tick;
   logic             busy;
   logic [CNT_W-1:0] cur_div;

   always #5 clk = ~clk;

   clk_div_ctrl #(
      .CNT_W   (CNT_W),
      .DEF_DIV (DEF_DIV)
   ) dut (
      .clk         (clk),
      .restn       (restn),
      .en          (en),
      .cfg_valid   (cfg_valid),
      .cfg_div     (cfg_div),
      .cfg_ready   (cfg_ready),
      .cfg_err     (cfg_err),
      .clk_div     (clk_div),
      .period_tick (period_tick),
      .busy        (busy),
      .cur_div     (cur_div)
   );

   typedef struct {
      int ratio;
      int len;
      int hi;
   } per_t;

   per_t exp_per[$];
   int   exp_err[$];
   int   checks = 0;
   int   errors = 0;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // One period of ratio n spans 2n half-cycle samples, n of them with clk_div high.
   task automatic push_periods(input int n, input int count);
      per_t e;
      for (int i = 0; i < count; i++) begin
         e.ratio = n;
         e.len   = 2 * n;
         e.hi    = n;
         exp_per.push_back(e);
      end
   endtask

   // Monitor: samples 2 time units after each clock edge.
   int len_h     = 0;
   int hi_h      = 0;
   bit tick_prev = 1'b0;

   task automatic sample(input bit pos_phase);
      per_t e;
      int   ee;
      if (!restn) begin
         len_h     = 0;
         hi_h      = 0;
         tick_prev = 1'b0;
      end else begin
         if (pos_phase && tick_prev) begin
            if (exp_per.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_period: len %0d hi %0d with nothing queued", len_h, hi_h);
            end else begin
               e = exp_per.pop_front();
               check($sformatf("period_len_N%0d", e.ratio), len_h, e.len);
               check($sformatf("period_high_N%0d", e.ratio), hi_h, e.hi);
            end
            len_h = 0;
            hi_h  = 0;
         end
         if (pos_phase) begin
            tick_prev = period_tick;
         end
         if (busy) begin
            len_h++;
            if (clk_div) hi_h++;
         end
         if (pos_phase && cfg_err) begin
            if (exp_err.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_cfg_err: cur_div %0d with nothing queued", cur_div);
            end else begin
               ee = exp_err.pop_front();
               check("cfg_err_cur_div", int'(cur_div), ee);
            end
         end
      end
   endtask

   initial begin
      forever begin
         @(posedge clk);
         #2;
         sample(1'b1);
         @(negedge clk);
         #2;
         sample(1'b0);
      end
   end

   task automatic wait_tick(input string name);
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!period_tick && n < 64);
      check({name, "_tick_seen"}, int'(period_tick), 1);
   endtask

   task automatic set_cfg(input int n);
      cfg_valid = 1'b1;
      cfg_div   = CNT_W'(n);
      @(negedge clk);
      cfg_valid = 1'b0;
   endtask

   initial begin
      #50000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      restn     = 1'b0;
      en        = 1'b0;
      cfg_valid = 1'b0;
      cfg_div   = '0;
      repeat (3) @(negedge clk);
      check("rst_cur_div", int'(cur_div), DEF_DIV);
      check("rst_cfg_ready", int'(cfg_ready), 1);
      check("rst_busy", int'(busy), 0);
      check("rst_clk_div", int'(clk_div), 0);
      check("rst_tick", int'(period_tick), 0);
      check("rst_cfg_err", int'(cfg_err), 0);
      restn = 1'b1;
      @(negedge clk);
      check("post_rst_ready", int'(cfg_ready), 1);

      // default ratio 5
      en = 1'b1;
      push_periods(5, 3);
      @(negedge clk);
      check("run5_busy", int'(busy), 1);
      wait_tick("run5_a");
      wait_tick("run5_b");
      wait_tick("run5_c");
      en = 1'b0;
      @(negedge clk);
      check("run5_idle_busy", int'(busy), 0);
      check("run5_idle_clk", int'(clk_div), 0);

      // ratio 4 programmed in IDLE
      cfg_valid = 1'b1;
      cfg_div   = 4'd4;
      check("idle_ready", int'(cfg_ready), 1);
      @(negedge clk);
      cfg_valid = 1'b0;
      check("idle_cur_div4", int'(cur_div), 4);
      en = 1'b1;
      push_periods(4, 2);
      wait_tick("run4_a");
      wait_tick("run4_b");
      en = 1'b0;
      @(negedge clk);
      check("run4_cur_div", int'(cur_div), 4);

      // 5 -> 6 requested mid-period
      set_cfg(5);
      en = 1'b1;
      push_periods(5, 1);
      push_periods(6, 2);
      repeat (2) @(negedge clk);
      cfg_valid = 1'b1;
      cfg_div   = 4'd6;
      check("run_ready", int'(cfg_ready), 1);
      @(negedge clk);
      cfg_valid = 1'b0;
      check("pend_ready", int'(cfg_ready), 0);
      check("pend_cur_div", int'(cur_div), 5);
      wait_tick("pend_bound");
      check("pend_ready_at_bound", int'(cfg_ready), 0);
      @(negedge clk);
      check("switch_ready", int'(cfg_ready), 1);
      check("switch_cur_div", int'(cur_div), 6);
      wait_tick("run6_a");
      wait_tick("run6_b");
      en = 1'b0;
      @(negedge clk);

      // illegal ratios 1 and 0 while running at 6
      en = 1'b1;
      push_periods(6, 2);
      repeat (2) @(negedge clk);
      cfg_valid = 1'b1;
      cfg_div   = 4'd1;
      exp_err.push_back(6);
      @(negedge clk);
      cfg_div = 4'd0;
      exp_err.push_back(6);
      @(negedge clk);
      cfg_valid = 1'b0;
      check("illegal_cur_div", int'(cur_div), 6);
      wait_tick("ill_a");
      wait_tick("ill_b");
      en = 1'b0;
      @(negedge clk);

      // en dropped at cnt=1 with ratio 7
      set_cfg(7);
      en = 1'b1;
      push_periods(7, 1);
      repeat (2) @(negedge clk);
      en = 1'b0;
      wait_tick("stop7");
      check("stop7_busy_last", int'(busy), 1);
      @(negedge clk);
      check("stop7_busy_idle", int'(busy), 0);
      check("stop7_clk_low", int'(clk_div), 0);
      repeat (3) @(negedge clk);
      check("stop7_clk_stays_low", int'(clk_div), 0);
      check("stop7_cur_div", int'(cur_div), 7);

      // reset while clk_div is high
      set_cfg(4);
      en = 1'b1;
      @(negedge clk);
      check("pre_rst_clk_high", int'(clk_div), 1);
      #3;
      restn = 1'b0;
      #1;
      check("async_rst_clk_div", int'(clk_div), 0);
      check("async_rst_busy", int'(busy), 0);
      check("async_rst_cur_div", int'(cur_div), DEF_DIV);
      en = 1'b0;
      @(negedge clk);
      restn = 1'b1;
      @(negedge clk);
      check("rel_cur_div", int'(cur_div), DEF_DIV);
      check("rel_cfg_ready", int'(cfg_ready), 1);
      check("rel_clk_div", int'(clk_div), 0);

      repeat (3) @(negedge clk);
      check("periods_left", exp_per.size(), 0);
      check("errs_left", exp_err.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
